// File: rtl/fp_pkg.sv
// Shared definitions for the fp adder issue/retire controller.
//   FP_W / EXP_MSB / EXP_LSB : IEEE-754 single-precision field layout
//   FPADD_LAT                : default adder pipeline latency
//   TAG_MAX_W                : widest user tag a track stage can carry
//   track_stage_t            : one entry of the in-flight tracking shift register
//   is_zero()                : +0 / -0 detection (sign ignored)
package fp_pkg;

  localparam int FP_W      = 32;
  localparam int EXP_MSB   = 30;
  localparam int EXP_LSB   = 23;
  localparam int FPADD_LAT = 10;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 vld;
    logic [TAG_MAX_W-1:0] tag;
    logic                 byp;
    logic [FP_W-1:0]      bypval;
  } track_stage_t;

  localparam track_stage_t TRACK_IDLE = '{
    vld:    1'b0,
    tag:    {TAG_MAX_W{1'b0}},
    byp:    1'b0,
    bypval: {FP_W{1'b0}}
  };

  // Zero exponent and zero mantissa; the sign bit does not matter.
  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == 8'd0) && (x[EXP_LSB-1:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fpadd_result_fifo.sv
// Result FIFO for the fp adder controller. Registered storage, read data is
// mem[rd] (not fall-through). Pop while empty and push while full are ignored.
//   clk, reset (async active-low)
//   push/wdata  : write one entry
//   pop         : release the head entry
//   rdata       : head entry
//   count       : occupancy 0..DEPTH
//   full/empty  : occupancy flags
module fpadd_result_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 36,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_r;
  logic [PW-1:0] rd_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualified push/pop and status flags.
  always_comb begin
    full      = (count_r == CW'(DEPTH));
    empty     = (count_r == CW'(0));
    do_push_s = push & ~full;
    do_pop_s  = pop & ~empty;
    count     = count_r;
    rdata     = mem_r[rd_r];
  end

  // Storage array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_r <= PW'(0);
      rd_r <= PW'(0);
    end else begin
      if (do_push_s) wr_r <= wr_r + PW'(1);
      if (do_pop_s)  rd_r <= rd_r + PW'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= CW'(0);
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Issue/retire controller around a fixed-latency, non-stallable fp adder.
//   in_valid/in_ready/in_a/in_b/in_tag : operand handshake
//   add_a/add_b                        : registered operands to the adder
//   add_sum                            : adder result, LAT cycles after add_a/add_b
//   out_valid/out_ready/out_sum/out_tag: result handshake (FIFO head)
//   busy                               : anything in flight or buffered
// Admission is credit based: an op is accepted only while in-flight plus
// buffered results are below DEPTH, so every retiring result has a FIFO slot.
// Zero operands bypass the adder through the tracking register, which keeps
// them in acceptance order with the real sums.
module fpadd_issue_ctrl
  import fp_pkg::*;
#(
  parameter int LAT   = FPADD_LAT,
  parameter int DEPTH = 16,
  parameter int TAGW  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  input  logic [31:0]     add_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_sum,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = FP_W + TAGW;

  logic            acc_s;
  logic            retire_s;
  logic            pop_s;
  logic            zero_a_s;
  logic            zero_b_s;
  logic            full_s;
  logic            empty_s;
  logic            unused_s;
  logic [CW-1:0]   inflight_r;
  logic [CW-1:0]   count_s;
  logic [CW:0]     credits_used_s;
  logic [FP_W-1:0] add_a_r;
  logic [FP_W-1:0] add_b_r;
  logic [FP_W-1:0] ret_sum_s;
  logic [FW-1:0]   push_data_s;
  logic [FW-1:0]   pop_data_s;
  track_stage_t    stage0_s;
  track_stage_t    trk_r [0:LAT];

  // Credit check, acceptance and the entry for tracking stage 0.
  always_comb begin
    credits_used_s  = {1'b0, inflight_r} + {1'b0, count_s};
    in_ready        = (credits_used_s < (CW + 1)'(DEPTH));
    acc_s           = in_valid & in_ready;
    zero_a_s        = is_zero(in_a);
    zero_b_s        = is_zero(in_b);
    stage0_s.vld    = acc_s;
    stage0_s.tag    = TAG_MAX_W'(in_tag);
    stage0_s.byp    = zero_a_s | zero_b_s;
    // With both operands zero the result is in_b.
    stage0_s.bypval = zero_a_s ? in_b : in_a;
  end

  // Retire path and output-side status.
  always_comb begin
    retire_s    = trk_r[LAT].vld;
    ret_sum_s   = trk_r[LAT].byp ? trk_r[LAT].bypval : add_sum;
    push_data_s = {ret_sum_s, trk_r[LAT].tag[TAGW-1:0]};
    pop_s       = ~empty_s & out_ready;
    out_valid   = ~empty_s;
    out_sum     = pop_data_s[FW-1:TAGW];
    out_tag     = pop_data_s[TAGW-1:0];
    busy        = (inflight_r != CW'(0)) | (count_s != CW'(0));
    add_a       = add_a_r;
    add_b       = add_b_r;
    unused_s    = ^{trk_r[LAT].tag, full_s};
  end

  // Adder operand registers; idle cycles feed zeros whose result is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      add_a_r <= {FP_W{1'b0}};
      add_b_r <= {FP_W{1'b0}};
    end else begin
      add_a_r <= acc_s ? in_a : {FP_W{1'b0}};
      add_b_r <= acc_s ? in_b : {FP_W{1'b0}};
    end
  end

  // Tracking shift register: one extra stage covers the operand register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= LAT; i++) begin
        trk_r[i] <= TRACK_IDLE;
      end
    end else begin
      trk_r[0] <= stage0_s;
      for (int i = 1; i <= LAT; i++) begin
        trk_r[i] <= trk_r[i-1];
      end
    end
  end

  // In-flight counter for credit accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= CW'(0);
    end else begin
      case ({acc_s, retire_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  fpadd_result_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (retire_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (pop_data_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Self-checking bench for fpadd_issue_ctrl: a behavioural adder of latency LAT,
// and a reference model built from a queue of accepted operations.
module tb_fpadd_issue_ctrl;

  localparam int LAT   = 10;
  localparam int DEPTH = 16;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_a = 32'd0;
  logic [31:0]     in_b = 32'd0;
  logic [TAGW-1:0] in_tag = 4'd0;
  logic [31:0]     add_a;
  logic [31:0]     add_b;
  logic [31:0]     add_sum;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [31:0]     out_sum;
  logic [TAGW-1:0] out_tag;
  logic            busy;

  fpadd_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural single-precision add ----------------
  function automatic real sp2real(input logic [31:0] x);
    logic [10:0] e;
    logic [63:0] d;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] sp_add(input logic [31:0] a, input logic [31:0] b);
    real         rs;
    logic [63:0] d;
    logic [10:0] e;
    rs = sp2real(a) + sp2real(b);
    if (rs == 0.0) return 32'd0;
    d = $realtobits(rs);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Adder pipeline: result of operands seen at an edge appears LAT edges later.
  logic [31:0] pipe [0:LAT-1];
  always @(posedge clk) begin
    pipe[0] <= sp_add(add_a, add_b);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum = pipe[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0]     sum;
    logic [TAGW-1:0] tag;
    int              rdy;   // first edge count at which it is visible
  } exp_t;

  exp_t            q[$];
  int              cyc = 0;
  int              n_vec = 0;
  int              n_err = 0;
  logic            last_acc;
  logic            last_pop;
  logic [31:0]     last_sum;
  logic [TAGW-1:0] last_tag;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 5) == 0) return {r[31], 31'd0};
    return {r[31], 8'($urandom_range(120, 134)), r[22:0]};
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0) return b;
    if (b[30:0] == 31'd0) return a;
    return sp_add(a, b);
  endfunction

  // One clock cycle; called at posedge+1 with inputs already driven.
  task automatic tick();
    logic        acc;
    logic        pop;
    logic [31:0] ea;
    logic [31:0] eb;
    exp_t        e;
    #2;
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < DEPTH});
    chk("busy", {63'd0, busy}, {63'd0, q.size() != 0});
    chk("out_valid", {63'd0, out_valid}, {63'd0, (q.size() > 0) && (q[0].rdy <= cyc)});
    acc = in_valid & in_ready;
    pop = out_valid & out_ready;
    last_acc = acc;
    last_pop = pop;
    last_sum = out_sum;
    last_tag = out_tag;
    if (pop && q.size() > 0 && q[0].rdy <= cyc) begin
      chk("out_sum", {32'd0, out_sum}, {32'd0, q[0].sum});
      chk("out_tag", {60'd0, out_tag}, {60'd0, q[0].tag});
      void'(q.pop_front());
    end
    if (acc) begin
      e.sum = model_result(in_a, in_b);
      e.tag = in_tag;
      e.rdy = cyc + LAT + 2;
      q.push_back(e);
    end
    ea = acc ? in_a : 32'd0;
    eb = acc ? in_b : 32'd0;
    @(posedge clk);
    cyc++;
    #1;
    chk("add_a", {32'd0, add_a}, {32'd0, ea});
    chk("add_b", {32'd0, add_b}, {32'd0, eb});
  endtask

  task automatic drain(input int budget);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int acc_n;
    int pop_n;
    int lat;
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_add_a", {32'd0, add_a}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ---------------- single op ----------------
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h40000000; in_tag = 4'd3;
    tick();
    chk("single_acc", {63'd0, last_acc}, 64'd1);
    in_valid = 1'b0;
    lat = 0;
    last_pop = 1'b0;
    while (!last_pop && lat < 40) begin
      tick();
      lat++;
    end
    chk("single_lat", 64'(lat), 64'(LAT + 2));
    chk("single_sum", {32'd0, last_sum}, 64'h40400000);
    chk("single_tag", {60'd0, last_tag}, 64'd3);
    chk("single_busy_after", {63'd0, busy}, 64'd0);

    // ---------------- backpressure: 20 offered, 16 accepted ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 20; i++) begin
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'(acc_n);
      tick();
      if (last_acc) acc_n++;
    end
    chk("bp_accepted", 64'(acc_n), 64'd16);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    pop_n = 0;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      tick();
      if (last_pop) begin
        chk("bp_tag_order", {60'd0, last_tag}, 64'(pop_n));
        pop_n++;
      end
    end
    chk("bp_popped", 64'(pop_n), 64'd16);

    // ---------------- full FIFO with simultaneous push/pop ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'($urandom);
      tick();
    end
    chk("full_outstanding", 64'(q.size()), 64'd16);
    out_ready = 1'b1;
    acc_n = 0;
    pop_n = 0;
    for (int i = 0; i < 40; i++) begin
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'($urandom);
      tick();
      if (last_acc) acc_n++;
      if (last_pop) pop_n++;
    end
    chk("full_accepts", 64'(acc_n), 64'd39);
    chk("full_pops", 64'(pop_n), 64'd40);
    drain(100);

    // ---------------- zero bypass ----------------
    in_valid = 1'b1; in_a = 32'h00000000; in_b = 32'h40A00000; in_tag = 4'd1;
    tick();
    in_a = 32'hC1200000; in_b = 32'h80000000; in_tag = 4'd2;
    tick();
    in_valid = 1'b0;
    pop_n = 0;
    for (int i = 0; i < 40 && pop_n < 2; i++) begin
      tick();
      if (last_pop) begin
        if (pop_n == 0) chk("byp_first", {32'd0, last_sum}, 64'h40A00000);
        else            chk("byp_second", {32'd0, last_sum}, 64'hC1200000);
        pop_n++;
      end
    end
    chk("byp_count", 64'(pop_n), 64'd2);

    // ---------------- idle bubbles 1,0,0,1 ----------------
    in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_tag = 4'd5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("bubble_add_a", {32'd0, add_a}, 64'd0);
    tick();
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3F800000; in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    pop_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_pop) pop_n++;
    end
    chk("bubble_results", 64'(pop_n), 64'd2);

    // ---------------- reset with 3 buffered and 5 in flight ----------------
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i < 3) || (i >= 10);
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pre_rst_outstanding", 64'(q.size()), 64'd8);
    chk("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("midrst_add_a", {32'd0, add_a}, 64'd0);
    q.delete();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();

    // ---------------- randomized traffic ----------------
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_a = rand_op(); in_b = rand_op(); in_tag = 4'($urandom);
      tick();
    end
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
